// File: rtl/led_event_scheduler.sv
// Indicator LED scheduler: serves latched event ticks as (id+1)-flash bursts.
// Optional build macro: LED_SCHED_FIXED_PRIO_EN selects fixed priority (lowest id wins).
module led_event_scheduler #(
  parameter int NREQ    = 4,
  parameter int ON_CYC  = 10_000_000,
  parameter int OFF_CYC = 5_000_000,
  parameter int GAP_CYC = 20_000_000,
  parameter int CNT_W   = 25,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic            led,
  output logic            busy,
  output logic [IDW-1:0]  grant_id,
  output logic            done,
  output logic [NREQ-1:0] pend
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDW-1:0]   ID_MAX   = IDW'(NREQ - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  timer, timer_n;
  logic [IDW-1:0]    flash, flash_n;
  logic [IDW-1:0]    gid_n;
  logic [IDW-1:0]    win_id;
  logic [NREQ-1:0]   clr;
  logic [NREQ-1:0]   pend_n;

`ifndef LED_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]    rr_ptr, rr_n;
`endif

  // Winner among pending flags; descending scan keeps the first hit from the start point.
  always_comb begin
    int idx;
    win_id = '0;
    idx    = 0;
`ifdef LED_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend[i]) win_id = IDW'(i);
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (pend[idx]) win_id = IDW'(idx);
    end
`endif
  end

  // Next-state, timer, flash and grant bookkeeping.
  always_comb begin
    state_n = state;
    timer_n = timer;
    flash_n = flash;
    gid_n   = grant_id;
    clr     = '0;
`ifndef LED_SCHED_FIXED_PRIO_EN
    rr_n    = rr_ptr;
`endif
    unique case (state)
      S_IDLE: begin
        if (|pend) begin
          gid_n   = win_id;
          clr     = NREQ'(1) << win_id;
          timer_n = '0;
          flash_n = '0;
          state_n = S_ON;
        end
      end
      S_ON: begin
        if (timer == ON_LAST) begin
          timer_n = '0;
          if (flash == grant_id) begin
            state_n = S_GAP;
          end else begin
            flash_n = flash + IDW'(1);
            state_n = S_OFF;
          end
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (timer == OFF_LAST) begin
          timer_n = '0;
          state_n = S_ON;
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          state_n = S_IDLE;
`ifndef LED_SCHED_FIXED_PRIO_EN
          rr_n    = (grant_id == ID_MAX) ? '0 : grant_id + IDW'(1);
`endif
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A tick on the grant edge wins over the clear, so the event re-arms.
  assign pend_n = (pend & ~clr) | req;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      flash    <= '0;
      grant_id <= '0;
      pend     <= '0;
`ifndef LED_SCHED_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      flash    <= flash_n;
      grant_id <= gid_n;
      pend     <= pend_n;
`ifndef LED_SCHED_FIXED_PRIO_EN
      rr_ptr   <= rr_n;
`endif
    end
  end

  assign led  = (state == S_ON);
  assign busy = (state != S_IDLE);
  assign done = (state == S_GAP) && (timer == GAP_LAST);

endmodule

// File: tb/tb_led_event_scheduler.sv
// Bench for led_event_scheduler: directed ticks, burst scoreboard.
// Expected grant order is queued by stimulus and checked on each done pulse.
module tb_led_event_scheduler;

  localparam int NREQ = 4;
  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int GAP  = 5;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            led;
  logic            busy;
  logic [1:0]      grant_id;
  logic            done;
  logic [NREQ-1:0] pend;

  int tests;
  int fails;
  int sb[$];

  led_event_scheduler #(
    .NREQ(NREQ),
    .ON_CYC(ON),
    .OFF_CYC(OFF),
    .GAP_CYC(GAP),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .led(led),
    .busy(busy),
    .grant_id(grant_id),
    .done(done),
    .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [NREQ-1:0] m);
    @(negedge clk);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && pend == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", int'(ok), 1);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_done", int'(ok), 1);
  endtask

  task automatic wait_led(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (led) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_led", int'(ok), 1);
  endtask

  // Burst monitor: measures each burst and compares it at its done pulse.
  initial begin
    int bc;
    int rises;
    int oncyc;
    int k;
    logic lp;
    bc = 0;
    rises = 0;
    oncyc = 0;
    lp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
        rises = 0;
        oncyc = 0;
        lp = 1'b0;
      end else begin
        if (busy) begin
          bc++;
          if (led) oncyc++;
          if (led && !lp) rises++;
        end
        lp = led;
        if (done) begin
          if (sb.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            k = sb.pop_front();
            check("burst_id", int'(grant_id), k);
            check("flashes", rises, k + 1);
            check("on_cycles", oncyc, (k + 1) * ON);
            check("burst_len", bc, (k + 1) * ON + k * OFF + GAP);
          end
          bc = 0;
          rises = 0;
          oncyc = 0;
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pend", int'(pend), 0);
    check("rst_gid", int'(grant_id), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Single tick for id 2, latency check.
    sb.push_back(2);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    check("single_pend", int'(pend), 4);
    check("single_led_pre", int'(led), 0);
    @(negedge clk);
    check("single_led", int'(led), 1);
    check("single_busy", int'(busy), 1);
    check("single_gid", int'(grant_id), 2);
    check("single_clr", int'(pend), 0);
    wait_idle(60);

    // Coalesce: id1 ticks thrice while id3 burst runs.
    sb.push_back(3);
    sb.push_back(1);
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    pulse(4'b0010);
    pulse(4'b0010);
    pulse(4'b0010);
    check("coal_pend", int'(pend), 2);
    wait_idle(120);

    // Re-arm: id0 held across its grant edge.
    sb.push_back(0);
    sb.push_back(0);
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    check("rearm_pend", int'(pend), 1);
    check("rearm_gid", int'(grant_id), 0);
    check("rearm_busy", int'(busy), 1);
    wait_idle(80);

    // Reset mid-ON aborts the burst for id3.
    pulse(4'b1000);
    wait_led(10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_led", int'(led), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_pend", int'(pend), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle", int'(busy), 0);

    // Three ticks at once: order 0,1,3.
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(3);
    pulse(4'b1011);
    check("rr_pend", int'(pend), 11);
    @(negedge clk);
    check("rr_first", int'(grant_id), 0);
    check("rr_pend2", int'(pend), 10);
    wait_idle(200);
    sb.push_back(0);
    pulse(4'b0001);
    @(negedge clk);
    check("rr_wrap", int'(grant_id), 0);
    wait_idle(40);

`ifdef LED_SCHED_FIXED_PRIO_EN
    // id3 stays pending while id0 keeps re-ticking.
    sb.push_back(0);
    sb.push_back(0);
    sb.push_back(0);
    sb.push_back(3);
    pulse(4'b1001);
    repeat (3) @(negedge clk);
    pulse(4'b0001);
    check("prio_pend", int'(pend), 9);
    wait_done(40);
    repeat (3) @(negedge clk);
    check("prio_gid", int'(grant_id), 0);
    pulse(4'b0001);
    wait_done(40);
    repeat (3) @(negedge clk);
    check("prio_gid2", int'(grant_id), 0);
    wait_idle(120);
    sb.push_back(0);
    sb.push_back(3);
`else
    // Pointer now at 1: id3 comes before id0.
    sb.push_back(3);
    sb.push_back(0);
`endif
    pulse(4'b1001);
    @(negedge clk);
    check("order_first", int'(grant_id), int'(sb[0]));
    wait_idle(120);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
